psram_qpi_responder: RTL and testbench
======================================

Name: psram_qpi_responder

Overview:
Synthesizable responder for the PSRAM SPI/QPI protocol. It models one PSRAM bank (one 4-bit SIO group) as seen from the device pins, and is used as the far-end partner of the memory controller. Typical uses are RTL simulation and on-FPGA loopback where no physical PSRAM is fitted. It decodes QPI-enable, quad write and quad fast-read transactions, backs them with an internal byte RAM, and drives read data back on the SIO lines.

Parameters:
ADDR_BITS, 10, internal RAM depth is 2^ADDR_BITS bytes; 24-bit bus address bits above ADDR_BITS-1 are ignored (aliasing).
WAIT_CYCLES, 6, sclk cycles between the last address nibble and the first read-data nibble for command 0xEB.
CMD_QPI_EN, 8'h35, SPI-mode command that enters QPI mode.
CMD_WRITE, 8'h38, QPI quad write.
CMD_READ, 8'hEB, QPI quad fast read.
CMD_QPI_EXIT, 8'hF5, QPI command that returns the device to SPI mode.

Ports:
i_clkRAM  in  1  system clock; must run at least 4x the sclk frequency
reset  in  1  synchronous, active-high
i_psram_sclk  in  1  PSRAM serial clock from the initiator
i_psram_cs  in  1  chip select, active-low
i_sio  in  4  SIO[3:0] input; in SPI mode the command is on bit 0 (SI)
o_sio  out  4  SIO[3:0] output value
o_sio_oe  out  1  output enable for o_sio; tristating is done by the enclosing wrapper
o_qpiMode  out  1  1 = QPI mode active
o_lastCmd  out  8  last fully received command byte
o_error  out  1  sticky; set when an unknown command is received; cleared only by reset

Behaviour:
- Reset: all outputs 0, state IDLE, SPI mode. RAM contents are not cleared.
- Edge detection:
  - i_psram_sclk, i_psram_cs and i_sio are registered once.
  - rise = sclk_q & ~sclk_qq; fall = ~sclk_q & sclk_qq.
  - Inputs are sampled on rise; outputs are updated on fall.
- CS high, seen registered, in any state:
  - Next cycle: state = IDLE, o_sio_oe = 0.
  - Any partial write byte is discarded.
  - o_qpiMode is unchanged.
- States: IDLE, SPI_CMD, QPI_CMD, ADDR, WR_DATA, WAIT, RD_DATA, IGNORE.
- IDLE: when CS falls, go to SPI_CMD if o_qpiMode = 0, else QPI_CMD. The bit/nibble counter is cleared.
- SPI_CMD:
  - Shift in i_sio[0], MSB first, for 8 rises.
  - Byte == CMD_QPI_EN: o_qpiMode = 1 at the 8th rise.
  - Any other byte: o_error is set.
  - Either way, go to IGNORE. o_lastCmd is updated.
- QPI_CMD:
  - Two rises; the first nibble is the high nibble, i_sio[3] is the MSB.
  - CMD_WRITE or CMD_READ: go to ADDR.
  - CMD_QPI_EXIT: o_qpiMode = 0, go to IGNORE.
  - Anything else: o_error = 1, go to IGNORE.
- ADDR: 6 rises, high nibble first, assembled into a 24-bit address. Then go to WR_DATA (write) or WAIT (read). For a read, the RAM read of addr[ADDR_BITS-1:0] is issued at this point.
- WR_DATA:
  - Rising-edge pairs form a byte: high nibble, then low nibble.
  - On the 2nd nibble: write RAM, then address +1 (wraps at 2^ADDR_BITS).
  - Burst continues until CS goes high.
  - o_sio_oe stays 0 throughout.
- WAIT: counts WAIT_CYCLES rises, then goes to RD_DATA. o_sio_oe stays 0.
- RD_DATA:
  - At the fall following the last WAIT rise: o_sio_oe = 1, o_sio = byte[7:4].
  - Next fall: o_sio = byte[3:0]. The address increments and the next byte is prefetched, so that byte's high nibble is on the following fall.
  - Burst continues until CS goes high.
- IGNORE: drives nothing and samples nothing; waits for CS high.
- A write and a read to the same address in consecutive transactions must return the new data; there is no read-during-write hazard.
- Reset asserted mid-transaction: takes effect on the next i_clkRAM edge. Same end state as the reset values; the in-flight byte is lost.

Decomposition:
- Shared package psram_pkg:
  - command constants 0x35, 0x38, 0xEB, 0xF5
  - responder state enum
  - default WAIT_CYCLES
  - The controller reuses the same constants.
- One sub-module: psram_resp_ram, a single-port synchronous byte RAM with 1-cycle read latency, parameterized by ADDR_BITS.
- The edge detector stays inline.

Test Plan:
- Reset, then CS low and SPI byte 0x35 on SIO0 -> o_qpiMode = 1, o_lastCmd = 0x35, o_error = 0, o_sio_oe = 0.
- QPI write: 0x38, address 0x00AAAA (nibbles 0,0,A,A,A,A), data 0xF0 -> RAM[0x2AA] = 0xF0; o_sio_oe stays 0; state IDLE after CS high.
- QPI read: 0xEB, address 0x00AAAA, 6 wait cycles -> o_sio_oe rises at the 6th-wait fall; o_sio = 0xF, then 0x0.
- Burst write of 0x11, 0x22, 0x33 at address 0x0003FF -> RAM[0x3FF] = 0x11, RAM[0x000] = 0x22, RAM[0x001] = 0x33 (wrap). A burst read from 0x0003FF returns the same three bytes.
- Abort and error handling:
  - CS high after 3 address nibbles -> state IDLE, no RAM change.
  - QPI command 0x5A -> o_error = 1, lines stay undriven until CS high.
  - 0xF5 -> o_qpiMode = 0.
- Reset asserted mid read burst -> next clock: o_sio_oe = 0, o_qpiMode = 0, state IDLE. RAM contents are preserved.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared PSRAM protocol constants and responder state encoding.
// Used by both the responder model and the memory controller.
`timescale 1ns/1ps
package psram_pkg;

    localparam logic [7:0] PSRAM_CMD_QPI_EN   = 8'h35;
    localparam logic [7:0] PSRAM_CMD_WRITE    = 8'h38;
    localparam logic [7:0] PSRAM_CMD_READ     = 8'hEB;
    localparam logic [7:0] PSRAM_CMD_QPI_EXIT = 8'hF5;

    localparam int PSRAM_WAIT_CYCLES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPI_CMD,
        ST_QPI_CMD,
        ST_ADDR,
        ST_WR_DATA,
        ST_WAIT,
        ST_RD_DATA,
        ST_IGNORE
    } resp_state_e;

endpackage

// File: rtl/psram_resp_ram.sv
// Single-port synchronous byte RAM, one-cycle read latency.
// Read data holds its value until the next read.
`timescale 1ns/1ps
module psram_resp_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/psram_qpi_responder.sv
// PSRAM SPI/QPI device-side responder backed by an internal byte RAM.
// Oversamples sclk/cs/sio on the system clock; samples on rise, drives on fall.
`timescale 1ns/1ps
module psram_qpi_responder
    import psram_pkg::*;
#(
    parameter int         ADDR_BITS    = 10,
    parameter int         WAIT_CYCLES  = PSRAM_WAIT_CYCLES,
    parameter logic [7:0] CMD_QPI_EN   = PSRAM_CMD_QPI_EN,
    parameter logic [7:0] CMD_WRITE    = PSRAM_CMD_WRITE,
    parameter logic [7:0] CMD_READ     = PSRAM_CMD_READ,
    parameter logic [7:0] CMD_QPI_EXIT = PSRAM_CMD_QPI_EXIT
) (
    input  logic       i_clkRAM,
    input  logic       reset,
    input  logic       i_psram_sclk,
    input  logic       i_psram_cs,
    input  logic [3:0] i_sio,
    output logic [3:0] o_sio,
    output logic       o_sio_oe,
    output logic       o_qpiMode,
    output logic [7:0] o_lastCmd,
    output logic       o_error
);

    logic        sclk_q, sclk_qq, cs_q, cs_qq;
    logic [3:0]  sio_q;
    logic        rise, fall, cs_fall;

    resp_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [6:0]  shreg_q, shreg_d;
    logic [23:0] addr_q, addr_d;
    logic        is_rd_q, is_rd_d;
    logic        phase_q, phase_d;
    logic [3:0]  sio_out_q, sio_d;
    logic        oe_q, oe_d, qpi_q, qpi_d, err_q, err_d;
    logic [7:0]  last_q, last_d;

    logic [7:0]  spi_byte, qpi_byte;
    logic [23:0] addr_shift, addr_inc;

    logic                 ram_we, ram_re;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [7:0]           ram_wdata, ram_rdata;

    assign rise       = sclk_q & ~sclk_qq;
    assign fall       = ~sclk_q & sclk_qq;
    assign cs_fall    = cs_qq & ~cs_q;
    assign spi_byte   = {shreg_q, sio_q[0]};
    assign qpi_byte   = {shreg_q[3:0], sio_q};
    assign addr_shift = {addr_q[19:0], sio_q};
    assign addr_inc   = addr_q + 24'd1;

    psram_resp_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (i_clkRAM),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge i_clkRAM) begin
        if (reset) begin
            sclk_q    <= 1'b0;
            sclk_qq   <= 1'b0;
            cs_q      <= 1'b0;
            cs_qq     <= 1'b0;
            sio_q     <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            addr_q    <= '0;
            is_rd_q   <= 1'b0;
            phase_q   <= 1'b0;
            sio_out_q <= '0;
            oe_q      <= 1'b0;
            qpi_q     <= 1'b0;
            last_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            sclk_q    <= i_psram_sclk;
            sclk_qq   <= sclk_q;
            cs_q      <= i_psram_cs;
            cs_qq     <= cs_q;
            sio_q     <= i_sio;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            addr_q    <= addr_d;
            is_rd_q   <= is_rd_d;
            phase_q   <= phase_d;
            sio_out_q <= sio_d;
            oe_q      <= oe_d;
            qpi_q     <= qpi_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        addr_d    = addr_q;
        is_rd_d   = is_rd_q;
        phase_d   = phase_q;
        sio_d     = sio_out_q;
        oe_d      = oe_q;
        qpi_d     = qpi_q;
        last_d    = last_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = addr_q[ADDR_BITS-1:0];
        ram_wdata = qpi_byte;
        if (cs_q) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = qpi_q ? ST_QPI_CMD : ST_SPI_CMD;
                        cnt_d   = '0;
                        phase_d = 1'b0;
                    end
                end
                ST_SPI_CMD: begin
                    if (rise) begin
                        shreg_d = spi_byte[6:0];
                        cnt_d   = cnt_q + 8'd1;
                        if (cnt_q == 8'd7) begin
                            last_d  = spi_byte;
                            state_d = ST_IGNORE;
                            if (spi_byte == CMD_QPI_EN) qpi_d = 1'b1;
                            else err_d = 1'b1;
                        end
                    end
                end
                ST_QPI_CMD: begin
                    if (rise) begin
                        shreg_d = {3'b000, sio_q};
                        cnt_d   = cnt_q + 8'd1;
                        if (cnt_q == 8'd1) begin
                            last_d = qpi_byte;
                            cnt_d  = '0;
                            unique case (1'b1)
                                qpi_byte == CMD_WRITE,
                                qpi_byte == CMD_READ: begin
                                    state_d = ST_ADDR;
                                    is_rd_d = (qpi_byte == CMD_READ);
                                end
                                qpi_byte == CMD_QPI_EXIT: begin
                                    qpi_d   = 1'b0;
                                    state_d = ST_IGNORE;
                                end
                                default: begin
                                    err_d   = 1'b1;
                                    state_d = ST_IGNORE;
                                end
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        addr_d = addr_shift;
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == 8'd5) begin
                            cnt_d   = '0;
                            phase_d = 1'b0;
                            if (is_rd_q) begin
                                state_d  = ST_WAIT;
                                ram_re   = 1'b1;
                                ram_addr = addr_shift[ADDR_BITS-1:0];
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (rise) begin
                        shreg_d = {3'b000, sio_q};
                        phase_d = ~phase_q;
                        if (phase_q) begin
                            ram_we = 1'b1;
                            addr_d = addr_inc;
                        end
                    end
                end
                ST_WAIT: begin
                    if (rise) begin
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == 8'(WAIT_CYCLES - 1)) begin
                            state_d = ST_RD_DATA;
                            phase_d = 1'b0;
                        end
                    end
                end
                ST_RD_DATA: begin
                    // Low-nibble fall prefetches the next byte for the next fall
                    if (fall) begin
                        if (!phase_q) begin
                            oe_d    = 1'b1;
                            sio_d   = ram_rdata[7:4];
                            phase_d = 1'b1;
                        end else begin
                            sio_d    = ram_rdata[3:0];
                            phase_d  = 1'b0;
                            addr_d   = addr_inc;
                            ram_re   = 1'b1;
                            ram_addr = addr_inc[ADDR_BITS-1:0];
                        end
                    end
                end
                ST_IGNORE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign o_sio     = sio_out_q;
    assign o_sio_oe  = oe_q;
    assign o_qpiMode = qpi_q;
    assign o_lastCmd = last_q;
    assign o_error   = err_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Bench for psram_qpi_responder: transaction-level model with byte memory,
// a per-cycle output comparator, and randomized write/read-back bursts.
`timescale 1ns/1ps
module tb_psram_qpi_responder;
    import psram_pkg::*;

    localparam int AB    = 10;
    localparam int DEPTH = 1 << AB;
    localparam int WAITS = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk, cs;
    logic [3:0] sio;
    logic [3:0] o_sio;
    logic       o_sio_oe, o_qpiMode, o_error;
    logic [7:0] o_lastCmd;

    always #5 clk = ~clk;

    psram_qpi_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(WAITS)) dut (
        .i_clkRAM     (clk),
        .reset        (reset),
        .i_psram_sclk (sclk),
        .i_psram_cs   (cs),
        .i_sio        (sio),
        .o_sio        (o_sio),
        .o_sio_oe     (o_sio_oe),
        .o_qpiMode    (o_qpiMode),
        .o_lastCmd    (o_lastCmd),
        .o_error      (o_error)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic       settled = 1'b0;
    logic       exp_oe = 1'b0, exp_qpi = 1'b0, exp_err = 1'b0;
    logic [3:0] exp_sio = 4'h0;
    logic [7:0] exp_last = 8'h00;
    logic [7:0] mem_m [DEPTH];

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endfunction

    function automatic logic [AB-1:0] widx(logic [23:0] a, int j);
        return AB'(a + 24'(j));
    endfunction

    always @(posedge clk) begin
        #1;
        if (settled) begin
            chk("sio_oe", 8'(o_sio_oe), 8'(exp_oe));
            chk("qpiMode", 8'(o_qpiMode), 8'(exp_qpi));
            chk("error", 8'(o_error), 8'(exp_err));
            chk("lastCmd", o_lastCmd, exp_last);
            if (exp_oe) chk("sio", 8'(o_sio), 8'(exp_sio));
        end
    end

    // One sclk half-period of 4 system clocks; outputs settle after 2.
    task automatic step(input logic c, input logic s, input logic [3:0] d);
        settled = 1'b0;
        cs = c;
        sclk = s;
        sio = d;
        @(negedge clk);
        settled = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic nib(input logic [3:0] d);
        step(1'b0, 1'b1, d);
        step(1'b0, 1'b0, d);
    endtask

    task automatic cs_begin();
        step(1'b0, 1'b0, 4'h0);
    endtask

    task automatic cs_end();
        exp_oe = 1'b0;
        step(1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0);
    endtask

    task automatic spi_cmd(input logic [7:0] b);
        cs_begin();
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                exp_last = b;
                if (b == PSRAM_CMD_QPI_EN) exp_qpi = 1'b1;
                else exp_err = 1'b1;
            end
            nib({3'b101, b[i]});
        end
        cs_end();
    endtask

    task automatic qpi_cmd(input logic [7:0] b);
        nib(b[7:4]);
        exp_last = b;
        if (b == PSRAM_CMD_QPI_EXIT) exp_qpi = 1'b0;
        else if (b != PSRAM_CMD_WRITE && b != PSRAM_CMD_READ) exp_err = 1'b1;
        nib(b[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
    endtask

    task automatic qpi_write(input logic [23:0] a, input logic [7:0] d[$]);
        cs_begin();
        qpi_cmd(PSRAM_CMD_WRITE);
        send_addr(a);
        foreach (d[j]) begin
            nib(d[j][7:4]);
            nib(d[j][3:0]);
            mem_m[widx(a, j)] = d[j];
        end
        cs_end();
    endtask

    // Leaves CS low so callers may abort or reset mid-burst.
    task automatic qpi_read(input logic [23:0] a, input int n,
                            output logic [7:0] got[$]);
        logic [3:0] hi;
        got = {};
        cs_begin();
        qpi_cmd(PSRAM_CMD_READ);
        send_addr(a);
        for (int w = 0; w < WAITS; w++) begin
            step(1'b0, 1'b1, 4'h0);
            if (w < WAITS - 1) step(1'b0, 1'b0, 4'h0);
        end
        for (int j = 0; j < n; j++) begin
            if (j > 0) step(1'b0, 1'b1, 4'h0);
            exp_oe = 1'b1;
            exp_sio = mem_m[widx(a, j)][7:4];
            step(1'b0, 1'b0, 4'h0);
            hi = o_sio;
            step(1'b0, 1'b1, 4'h0);
            exp_sio = mem_m[widx(a, j)][3:0];
            step(1'b0, 1'b0, 4'h0);
            got.push_back({hi, o_sio});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  wd[$];
        logic [7:0]  got[$];
        logic [23:0] ra;
        int          n;

        reset = 1'b1;
        cs = 1'b1;
        sclk = 1'b0;
        sio = 4'h0;
        repeat (2) @(negedge clk);
        settled = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_lastCmd", o_lastCmd, 8'h00);
        chk("reset_oe", 8'(o_sio_oe), 8'h00);
        reset = 1'b0;
        step(1'b1, 1'b0, 4'h0);

        spi_cmd(8'h35);
        chk("qpi_after_35", 8'(o_qpiMode), 8'h01);
        chk("last_after_35", o_lastCmd, 8'h35);

        wd = {};
        wd.push_back(8'hF0);
        qpi_write(24'h00AAAA, wd);
        qpi_read(24'h00AAAA, 1, got);
        cs_end();
        chk("read_aaaa", got[0], 8'hF0);

        wd = {};
        wd.push_back(8'h11);
        wd.push_back(8'h22);
        wd.push_back(8'h33);
        qpi_write(24'h0003FF, wd);
        qpi_read(24'h0003FF, 3, got);
        cs_end();
        chk("wrap_b0", got[0], 8'h11);
        chk("wrap_b1", got[1], 8'h22);
        chk("wrap_b2", got[2], 8'h33);

        cs_begin();
        qpi_cmd(PSRAM_CMD_WRITE);
        nib(4'h0);
        nib(4'h0);
        nib(4'hA);
        cs_end();
        qpi_read(24'h00AAAA, 1, got);
        cs_end();
        chk("abort_keeps_ram", got[0], 8'hF0);

        cs_begin();
        qpi_cmd(8'h5A);
        for (int i = 0; i < 4; i++) nib(4'($urandom));
        cs_end();
        chk("err_after_5a", 8'(o_error), 8'h01);

        cs_begin();
        qpi_cmd(PSRAM_CMD_QPI_EXIT);
        cs_end();
        chk("qpi_after_f5", 8'(o_qpiMode), 8'h00);

        spi_cmd(8'h35);
        qpi_read(24'h0003FF, 2, got);
        settled = 1'b0;
        reset = 1'b1;
        exp_oe = 1'b0;
        exp_qpi = 1'b0;
        exp_err = 1'b0;
        exp_last = 8'h00;
        @(posedge clk);
        #1;
        chk("rst_oe_next_clk", 8'(o_sio_oe), 8'h00);
        chk("rst_qpi_next_clk", 8'(o_qpiMode), 8'h00);
        @(negedge clk);
        settled = 1'b1;
        repeat (2) @(negedge clk);
        step(1'b1, 1'b0, 4'h0);
        reset = 1'b0;
        step(1'b1, 1'b0, 4'h0);

        spi_cmd(8'h35);
        qpi_read(24'h0003FF, 3, got);
        cs_end();
        chk("ram_kept_b0", got[0], 8'h11);
        chk("ram_kept_b1", got[1], 8'h22);
        chk("ram_kept_b2", got[2], 8'h33);

        for (int it = 0; it < 20; it++) begin
            ra = 24'($urandom);
            n = $urandom_range(1, 6);
            wd = {};
            for (int k = 0; k < n; k++) wd.push_back(8'($urandom));
            qpi_write(ra, wd);
            qpi_read(ra, n, got);
            cs_end();
            for (int k = 0; k < n; k++) chk("rand_readback", got[k], wd[k]);
            if ($urandom_range(0, 3) == 0) begin
                cs_begin();
                qpi_cmd(PSRAM_CMD_QPI_EXIT);
                cs_end();
                spi_cmd(8'h35);
            end
        end

        cs_begin();
        qpi_cmd(PSRAM_CMD_QPI_EXIT);
        cs_end();
        spi_cmd(8'h9F);
        chk("spi_bad_err", 8'(o_error), 8'h01);
        chk("spi_bad_last", o_lastCmd, 8'h9F);
        chk("spi_bad_qpi", 8'(o_qpiMode), 8'h00);

        settled = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
